// File: rtl/sys_ctrl_ibus.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sys_ctrl_ibus : ibus control window that sequences an array RUN/DRAIN    |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module sys_ctrl_ibus #(
  parameter logic [15:0] ADR_BASE = 16'hFFF0,
  parameter int          CW       = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ren,
  input  logic [15:0]   ibus_radr,
  output logic [15:0]   ibus_rdata,
  input  logic          wen,
  input  logic [15:0]   ibus_wadr,
  input  logic [15:0]   ibus_wdata,
  output logic          pe_en,
  output logic [CW-1:0] buf_radr,
  output logic          drain,
  output logic          busy,
  output logic          done
);

  localparam logic [15:0]   c_ADR_START  = ADR_BASE;
  localparam logic [15:0]   c_ADR_MAX    = ADR_BASE + 16'd1;
  localparam logic [15:0]   c_ADR_RUN    = ADR_BASE + 16'd2;
  localparam logic [15:0]   c_ADR_STATUS = ADR_BASE + 16'd3;
  localparam logic [15:0]   c_ADR_CYCLE  = ADR_BASE + 16'd4;
  localparam logic [CW-1:0] c_CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   r_max;
  logic [CW-1:0]   r_run;
  logic            r_sticky;
  logic [15:0]     r_rdata;
  logic            r_pe_en;
  logic            r_drain;
  logic            r_busy;
  logic            r_done;
  logic [CW-1:0]   r_buf_radr;

  logic [CW-1:0]   w_wdata_cw;
  logic            w_start;
  logic            w_wr_max;
  logic            w_wr_run;
  logic            w_rd_status;
  logic            w_enter_done;
  logic [CW-1:0]   w_cycle;

  assign w_wdata_cw   = CW'(ibus_wdata);
  assign w_start      = wen && (ibus_wadr == c_ADR_START) && ibus_wdata[0] && (r_state == S_IDLE);
  assign w_wr_max     = wen && (ibus_wadr == c_ADR_MAX) && !r_busy;
  assign w_wr_run     = wen && (ibus_wadr == c_ADR_RUN) && !r_busy;
  assign w_rd_status  = ren && (ibus_radr == c_ADR_STATUS);
  assign w_enter_done = (r_state == S_DRAIN) && (r_cnt == r_run);
  assign w_cycle      = r_busy ? r_cnt : '0;

  // Outputs are registered alongside the state so no ibus input reaches them combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_pe_en    <= 1'b0;
      r_drain    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_buf_radr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state    <= S_RUN;
            r_cnt      <= '0;
            r_pe_en    <= 1'b1;
            r_busy     <= 1'b1;
            r_buf_radr <= '0;
          end
        end
        S_RUN: begin
          if (r_cnt == r_max) begin
            r_state    <= S_DRAIN;
            r_cnt      <= '0;
            r_pe_en    <= 1'b0;
            r_drain    <= 1'b1;
            r_buf_radr <= '0;
          end else begin
            r_cnt      <= r_cnt + c_CNT_ONE;
            r_buf_radr <= r_cnt + c_CNT_ONE;
          end
        end
        S_DRAIN: begin
          if (w_enter_done) begin
            r_state <= S_DONE;
            r_cnt   <= '0;
            r_drain <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_cnt      <= '0;
          r_pe_en    <= 1'b0;
          r_drain    <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_buf_radr <= '0;
        end
      endcase
    end
  end

  // Sticky set takes priority over the clear from a STATUS read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max    <= '0;
      r_run    <= '0;
      r_sticky <= 1'b0;
    end else begin
      if (w_wr_max) r_max <= w_wdata_cw;
      if (w_wr_run) r_run <= w_wdata_cw;
      if (w_enter_done)
        r_sticky <= 1'b1;
      else if (w_rd_status || w_start)
        r_sticky <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (ren) begin
      case (ibus_radr)
        c_ADR_MAX:    r_rdata <= 16'(r_max);
        c_ADR_RUN:    r_rdata <= 16'(r_run);
        c_ADR_STATUS: r_rdata <= {14'd0, r_sticky, r_busy};
        c_ADR_CYCLE:  r_rdata <= 16'(w_cycle);
        default:      r_rdata <= '0;
      endcase
    end
  end

  assign ibus_rdata = r_rdata;
  assign pe_en      = r_pe_en;
  assign drain      = r_drain;
  assign busy       = r_busy;
  assign done       = r_done;
  assign buf_radr   = r_buf_radr;

endmodule
`default_nettype wire

// File: tb/tb_sys_ctrl_ibus.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sys_ctrl_ibus : self-checking bench for the ibus control window       |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_sys_ctrl_ibus;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ren = 1'b0;
  logic        wen = 1'b0;
  logic [15:0] radr = '0;
  logic [15:0] wadr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic        pe_en, drain, busy, done;
  logic [15:0] buf_radr;

  int vec = 0;
  int miss = 0;

  sys_ctrl_ibus #(.ADR_BASE(16'hFFF0), .CW(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ren        (ren),
    .ibus_radr  (radr),
    .ibus_rdata (rdata),
    .wen        (wen),
    .ibus_wadr  (wadr),
    .ibus_wdata (wdata),
    .pe_en      (pe_en),
    .buf_radr   (buf_radr),
    .drain      (drain),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    wen = 1'b1; wadr = a; wdata = d;
    step();
    wen = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] d);
    ren = 1'b1; radr = a;
    step();
    ren = 1'b0;
    d = rdata;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    #2 rst_n = 1'b0;
    #1;
    vec++;
    if ({pe_en, drain, busy, done, buf_radr, rdata} !== 36'd0) begin
      miss++; $display("FAIL reset_outputs: got %h expected 0", {pe_en, drain, busy, done, buf_radr, rdata});
    end
    step(); step();
    rst_n = 1'b1;
    step();
    rd(16'hFFF1, d); vec++;
    if (d !== 16'h0000) begin miss++; $display("FAIL reset_max: got %h expected 0000", d); end
    rd(16'hFFF2, d); vec++;
    if (d !== 16'h0000) begin miss++; $display("FAIL reset_run: got %h expected 0000", d); end
    rd(16'hFFF3, d); vec++;
    if (d !== 16'h0000) begin miss++; $display("FAIL reset_status: got %h expected 0000", d); end
  endtask

  task automatic test_basic();
    logic [15:0] d;
    wr(16'hFFF1, 16'd3);
    wr(16'hFFF2, 16'd3);
    wr(16'hFFF0, 16'hFFFF);
    for (int t = 0; t < 4; t++) begin
      vec++;
      if ({pe_en, drain, busy, done, buf_radr} !== {4'b1010, 16'(t)}) begin
        miss++; $display("FAIL basic_run[%0d]: got %h expected %h", t, {pe_en, drain, busy, done, buf_radr}, {4'b1010, 16'(t)});
      end
      step();
    end
    for (int t = 0; t < 4; t++) begin
      vec++;
      if ({pe_en, drain, busy, done, buf_radr} !== {4'b0110, 16'd0}) begin
        miss++; $display("FAIL basic_drain[%0d]: got %h expected %h", t, {pe_en, drain, busy, done, buf_radr}, {4'b0110, 16'd0});
      end
      step();
    end
    vec++;
    if ({pe_en, drain, busy, done, buf_radr} !== {4'b0001, 16'd0}) begin
      miss++; $display("FAIL basic_done: got %h expected %h", {pe_en, drain, busy, done, buf_radr}, {4'b0001, 16'd0});
    end
    step();
    vec++;
    if ({pe_en, drain, busy, done} !== 4'b0000) begin
      miss++; $display("FAIL basic_idle: got %b expected 0000", {pe_en, drain, busy, done});
    end
    rd(16'hFFF3, d); vec++;
    if (d !== 16'h0002) begin miss++; $display("FAIL basic_status1: got %h expected 0002", d); end
    rd(16'hFFF3, d); vec++;
    if (d !== 16'h0000) begin miss++; $display("FAIL basic_status2: got %h expected 0000", d); end
  endtask

  task automatic test_zero();
    logic [19:0] exp_z [3];
    exp_z[0] = {4'b1010, 16'd0};
    exp_z[1] = {4'b0110, 16'd0};
    exp_z[2] = {4'b0001, 16'd0};
    wr(16'hFFF1, 16'd0);
    wr(16'hFFF2, 16'd0);
    wr(16'hFFF0, 16'h0001);
    for (int t = 0; t < 3; t++) begin
      vec++;
      if ({pe_en, drain, busy, done, buf_radr} !== exp_z[t]) begin
        miss++; $display("FAIL zero_cycle[%0d]: got %h expected %h", t, {pe_en, drain, busy, done, buf_radr}, exp_z[t]);
      end
      step();
    end
  endtask

  task automatic test_busy_writes();
    logic [15:0] d;
    wr(16'hFFF1, 16'd4);
    wr(16'hFFF2, 16'd2);
    wr(16'hFFF0, 16'h0001);
    wr(16'hFFF1, 16'd9);
    wr(16'hFFF0, 16'h0001);
    rd(16'hFFF3, d); vec++;
    if (d !== 16'h0001) begin miss++; $display("FAIL busy_status: got %h expected 0001", d); end
    rd(16'hFFF1, d); vec++;
    if (d !== 16'h0004) begin miss++; $display("FAIL busy_max_read: got %h expected 0004", d); end
    vec++;
    if ({pe_en, drain, buf_radr} !== {2'b10, 16'd4}) begin
      miss++; $display("FAIL busy_run_tail: got %h expected %h", {pe_en, drain, buf_radr}, {2'b10, 16'd4});
    end
    step();
    for (int t = 0; t < 3; t++) begin
      vec++;
      if ({pe_en, drain, busy, done} !== 4'b0110) begin
        miss++; $display("FAIL busy_drain[%0d]: got %b expected 0110", t, {pe_en, drain, busy, done});
      end
      step();
    end
    vec++;
    if (done !== 1'b1) begin miss++; $display("FAIL busy_done: got %b expected 1", done); end
    step();
    vec++;
    if ({pe_en, busy} !== 2'b00) begin miss++; $display("FAIL busy_no_restart: got %b expected 00", {pe_en, busy}); end
  endtask

  task automatic test_invalid();
    logic [15:0] d;
    wr(16'hFFF0, 16'hFFFE);
    vec++;
    if ({pe_en, busy} !== 2'b00) begin miss++; $display("FAIL inv_start_even: got %b expected 00", {pe_en, busy}); end
    wr(16'h1234, 16'hBEEF);
    rd(16'h1234, d); vec++;
    if (d !== 16'h0000) begin miss++; $display("FAIL inv_rd_1234: got %h expected 0000", d); end
    rd(16'hFFF6, d); vec++;
    if (d !== 16'h0000) begin miss++; $display("FAIL inv_rd_fff6: got %h expected 0000", d); end
    rd(16'hFFF0, d); vec++;
    if (d !== 16'h0000) begin miss++; $display("FAIL inv_rd_start: got %h expected 0000", d); end
    rd(16'hFFF1, d); vec++;
    if (d !== 16'h0004) begin miss++; $display("FAIL inv_max_kept: got %h expected 0004", d); end
  endtask

  task automatic test_rw_collision();
    logic [15:0] d;
    wr(16'hFFF1, 16'hA5A5);
    ren = 1'b1; radr = 16'hFFF1;
    wen = 1'b1; wadr = 16'hFFF1; wdata = 16'h1111;
    step();
    ren = 1'b0; wen = 1'b0;
    vec++;
    if (rdata !== 16'hA5A5) begin miss++; $display("FAIL coll_pre_write: got %h expected a5a5", rdata); end
    rd(16'hFFF1, d); vec++;
    if (d !== 16'h1111) begin miss++; $display("FAIL coll_post_write: got %h expected 1111", d); end
    wr(16'hFFF2, 16'h0007);
    vec++;
    if (rdata !== 16'h1111) begin miss++; $display("FAIL coll_hold: got %h expected 1111", rdata); end
    rd(16'hFFF2, d); vec++;
    if (d !== 16'h0007) begin miss++; $display("FAIL coll_run_read: got %h expected 0007", d); end
  endtask

  task automatic test_async_reset();
    logic [15:0] d;
    wr(16'hFFF1, 16'd5);
    wr(16'hFFF2, 16'd1);
    rd(16'hFFF1, d);
    wr(16'hFFF0, 16'h0001);
    for (int k = 0; k < 20 && buf_radr !== 16'd2; k++) step();
    vec++;
    if (buf_radr !== 16'd2) begin miss++; $display("FAIL arst_wait: got %h expected 0002", buf_radr); end
    #2 rst_n = 1'b0;
    #1;
    vec++;
    if ({pe_en, drain, busy, done, buf_radr, rdata} !== 36'd0) begin
      miss++; $display("FAIL arst_immediate: got %h expected 0", {pe_en, drain, busy, done, buf_radr, rdata});
    end
    for (int k = 0; k < 3; k++) step();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      vec++;
      if ({pe_en, drain, busy, done} !== 4'b0000) begin
        miss++; $display("FAIL arst_quiet[%0d]: got %b expected 0000", k, {pe_en, drain, busy, done});
      end
      step();
    end
    rd(16'hFFF1, d); vec++;
    if (d !== 16'h0000) begin miss++; $display("FAIL arst_max: got %h expected 0000", d); end
  endtask

  task automatic test_random();
    logic [15:0] d, a, e;
    int m, r;
    logic sticky;
    sticky = 1'b0;
    for (int it = 0; it < 25; it++) begin
      m = $urandom_range(0, 12);
      r = $urandom_range(0, 12);
      wr(16'hFFF1, 16'(m));
      wr(16'hFFF2, 16'(r));
      wr(16'hFFF0 + 16'($urandom_range(3, 7)), 16'($urandom));
      a = ($urandom_range(0, 1) == 1) ? 16'hFFF0 + 16'($urandom_range(0, 7)) : 16'($urandom);
      case (a)
        16'hFFF1: e = 16'(m);
        16'hFFF2: e = 16'(r);
        16'hFFF3: e = {14'd0, sticky, 1'b0};
        default:  e = 16'h0000;
      endcase
      if (a == 16'hFFF3) sticky = 1'b0;
      rd(a, d); vec++;
      if (d !== e) begin miss++; $display("FAIL rnd_read[%0d] adr %h: got %h expected %h", it, a, d, e); end
      wr(16'hFFF0, 16'($urandom) | 16'h0001);
      sticky = 1'b0;
      for (int t = 0; t <= m + r + 2; t++) begin
        logic [19:0] x;
        if (t <= m)              x = {4'b1010, 16'(t)};
        else if (t <= m + r + 1) x = {4'b0110, 16'd0};
        else                     x = {4'b0001, 16'd0};
        vec++;
        if ({pe_en, drain, busy, done, buf_radr} !== x) begin
          miss++; $display("FAIL rnd_seq[%0d] m=%0d r=%0d t=%0d: got %h expected %h", it, m, r, t, {pe_en, drain, busy, done, buf_radr}, x);
        end
        step();
      end
      sticky = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        rd(16'hFFF3, d); vec++;
        if (d !== 16'h0002) begin miss++; $display("FAIL rnd_status[%0d]: got %h expected 0002", it, d); end
        sticky = 1'b0;
      end
    end
  endtask

  task automatic test_max_wrap();
    logic bad;
    bad = 1'b0;
    wr(16'hFFF1, 16'hFFFF);
    wr(16'hFFF2, 16'h0000);
    wr(16'hFFF0, 16'h0001);
    for (int t = 0; t < 65536 && !bad; t++) begin
      vec++;
      if ({pe_en, drain, busy, buf_radr} !== {3'b101, 16'(t)}) begin
        miss++; bad = 1'b1;
        $display("FAIL wrap_run[%0d]: got %h expected %h", t, {pe_en, drain, busy, buf_radr}, {3'b101, 16'(t)});
      end
      step();
    end
    vec++;
    if ({pe_en, drain, busy, done} !== 4'b0110) begin
      miss++; $display("FAIL wrap_drain: got %b expected 0110", {pe_en, drain, busy, done});
    end
    step();
    vec++;
    if ({pe_en, drain, busy, done} !== 4'b0001) begin
      miss++; $display("FAIL wrap_done: got %b expected 0001", {pe_en, drain, busy, done});
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_busy_writes();
    test_invalid();
    test_rw_collision();
    test_async_reset();
    test_random();
    test_max_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
`default_nettype wire
